hive_alu_divide: RTL
====================

HIVE_ALU_DIVIDE -- requirements
Module: hive_alu_divide

Interface
REQ-001 Parameter DATA_W, default 32, operand, quotient and remainder width; legal values 4 to 64.
REQ-002 clk_i  input  1  clock; all state changes on the rising edge.
REQ-003 rst_i  input  1  asynchronous, active-low reset.
REQ-004 start_i  input  1  request to begin a division; sampled on the rising edge.
REQ-005 sgn_i  input  1  1 = signed (two's complement) operands, 0 = unsigned; sampled with start_i.
REQ-006 a_i  input  DATA_W  dividend; sampled with start_i.
REQ-007 b_i  input  DATA_W  divisor; sampled with start_i.
REQ-008 busy_o  output  1  1 while a division is in progress.
REQ-009 done_o  output  1  single-cycle pulse when results are valid.
REQ-010 quo_o  output  DATA_W  quotient.
REQ-011 rem_o  output  DATA_W  remainder.
REQ-012 dbz_o  output  1  divide-by-zero flag for the current result.

Function
REQ-013 The block SHALL use three states:
- IDLE
- CALC, iterative radix-2 restoring division, one quotient bit per cycle
- FIX, sign correction and output registering
REQ-014 start_i SHALL be accepted only in IDLE; the edge that accepts it SHALL:
- capture sgn_i
- capture the operand magnitudes (absolute values when sgn_i=1, raw values when sgn_i=0)
- capture sign flags sq = sa XOR sb and sr = sa, where sa and sb are the operand MSbs when sgn_i=1 and 0 otherwise
- load the iteration counter
- enter CALC
REQ-015 CALC SHALL run exactly DATA_W cycles and then enter FIX; FIX SHALL last one cycle and then return to IDLE.
REQ-016 Cycle numbering is relative to the accepting cycle, which is cycle 0:
- busy_o SHALL be 1 in cycles 1 through DATA_W+1 and 0 otherwise
- done_o SHALL be 1 only in cycle DATA_W+2
REQ-017 start_i asserted while busy_o=1 SHALL be ignored and SHALL NOT be queued.
REQ-018 start_i SHALL be accepted in the cycle where done_o=1, giving back-to-back operation every DATA_W+2 cycles.
REQ-019 Each CALC step SHALL shift the partial remainder left by one, bringing in the next dividend MSb.
- The divisor magnitude SHALL be subtracted on a DATA_W+1-bit datapath.
- The quotient bit SHALL be set and the difference kept when non-negative; otherwise the bit SHALL be cleared and the partial remainder kept.
REQ-020 In FIX, quo_o SHALL receive the quotient magnitude, negated when sq=1.
REQ-021 In FIX, rem_o SHALL receive the remainder magnitude, negated when sr=1 (remainder takes the sign of the dividend; quotient truncates toward zero).
REQ-022 Divisor zero SHALL override REQ-020/REQ-021 regardless of sgn_i:
- quo_o = all ones
- rem_o = original dividend a_i
- dbz_o = 1
REQ-023 Signed overflow (a_i = most-negative value, b_i = -1, sgn_i=1) SHALL produce quo_o = most-negative value, rem_o = 0 and dbz_o = 0, with no other flag.
REQ-024 quo_o, rem_o and dbz_o SHALL update only in FIX and SHALL hold their values until the next FIX; they are undefined for consumers except when done_o=1.
REQ-025 All arithmetic SHALL be modulo 2^DATA_W on outputs; no internal register SHALL exceed DATA_W+1 bits except the shift/quotient pair, which SHALL be at most 2*DATA_W+1 bits.

Reset
REQ-026 rst_i low SHALL immediately force:
- state IDLE
- busy_o=0, done_o=0, dbz_o=0
- quo_o=0, rem_o=0
- all internal registers to 0
REQ-027 Reset asserted mid-division SHALL abandon the operation without producing done_o.
REQ-028 After reset deassertion, the first rising edge with start_i=1 SHALL be accepted.

Verification (DATA_W=32)
REQ-029 Unsigned 100 / 7 -> done_o exactly 34 cycles after the accepting cycle; quo_o=14, rem_o=2, dbz_o=0.
REQ-030 Signed -7 / 2 -> quo_o=0xFFFFFFFD, rem_o=0xFFFFFFFF.
REQ-031 Signed 7 / -2 -> quo_o=0xFFFFFFFD, rem_o=1.
REQ-032 Divide by zero, 5 / 0 with both sgn_i values -> quo_o=0xFFFFFFFF, rem_o=5, dbz_o=1.
REQ-033 Signed 0x80000000 / 0xFFFFFFFF -> quo_o=0x80000000, rem_o=0, dbz_o=0.
REQ-034 Unsigned 0xFFFFFFFF / 1 -> quo_o=0xFFFFFFFF, rem_o=0.
REQ-035 Handshake and reset sequence:
- start_i re-pulsed at cycle 10 of a division -> ignored; original result and timing unchanged
- start_i held high continuously -> done_o pulses every 34 cycles
- rst_i low at cycle 15 -> busy_o=0 immediately, no done_o, outputs 0

Source files
------------

// File: rtl/hive_alu_divide.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle, with signed/unsigned
// operands, divide-by-zero reporting and a one-cycle sign-fix stage.
module hive_alu_divide #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              sgn_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] quo_o,
  output logic [DATA_W-1:0] rem_o,
  output logic              dbz_o
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sgn_q, sgn_d;
  logic              sq_q, sq_d;
  logic              sr_q, sr_d;
  logic              bz_q, bz_d;
  logic [DATA_W-1:0] div_q, div_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] quo_o_q, quo_o_d;
  logic [DATA_W-1:0] rem_o_q, rem_o_d;
  logic              dbz_o_q, dbz_o_d;
  logic              done_q, done_d;

  logic              sa_w, sb_w;
  logic [DATA_W:0]   shift_w, diff_w;

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic              neg);
    cond_neg = neg ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

  assign sa_w = sgn_i & a_i[DATA_W-1];
  assign sb_w = sgn_i & b_i[DATA_W-1];

  // quo_q starts as the dividend magnitude and is shifted out MSb-first while
  // quotient bits are shifted in at the bottom.
  assign shift_w = {rem_q, quo_q[DATA_W-1]};
  assign diff_w  = shift_w - {1'b0, div_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    bz_d    = bz_q;
    div_d   = div_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    quo_o_d = quo_o_q;
    rem_o_d = rem_o_q;
    dbz_o_d = dbz_o_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          sgn_d   = sgn_i;
          sq_d    = sa_w ^ sb_w;
          sr_d    = sa_w;
          bz_d    = (b_i == '0);
          quo_d   = cond_neg(a_i, sa_w);
          div_d   = cond_neg(b_i, sb_w);
          rem_d   = '0;
          cnt_d   = CW'(DATA_W);
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        // Partial remainder stays below the divisor, so DATA_W bits hold it.
        if (!diff_w[DATA_W]) begin
          rem_d = diff_w[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
          rem_d = shift_w[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        // A zero divisor leaves the dividend magnitude in rem_q, so re-applying
        // the dividend sign restores the original a_i.
        quo_o_d = bz_q ? '1 : cond_neg(quo_q, sgn_q & sq_q);
        rem_o_d = cond_neg(rem_q, sgn_q & sr_q);
        dbz_o_d = bz_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      bz_q    <= 1'b0;
      div_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      quo_o_q <= '0;
      rem_o_q <= '0;
      dbz_o_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      bz_q    <= bz_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      quo_o_q <= quo_o_d;
      rem_o_q <= rem_o_d;
      dbz_o_q <= dbz_o_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;
  assign quo_o  = quo_o_q;
  assign rem_o  = rem_o_q;
  assign dbz_o  = dbz_o_q;

endmodule
